// File: rtl/lvg_pkg.sv
// Shared opcode constants, FSM state encoding and opcode decode helpers for
// the lvg instruction scheduler.
package lvg_pkg;

  localparam logic [7:0] OP_NOP       = 8'd0;
  localparam logic [7:0] OP_LOADL     = 8'd1;
  localparam logic [7:0] OP_LOADR     = 8'd2;
  localparam logic [7:0] OP_STORE     = 8'd3;
  localparam logic [7:0] OP_MUL       = 8'd4;
  localparam logic [7:0] OP_MULADD    = 8'd5;
  localparam logic [7:0] OP_MULACT    = 8'd6;
  localparam logic [7:0] OP_MULADDACT = 8'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // NOP is not a schedulable operation; only 1..7 reach the engine.
  function automatic logic op_legal(input logic [7:0] op);
    return (op >= OP_LOADL) && (op <= OP_MULADDACT);
  endfunction

  function automatic int unsigned op_len(input logic [7:0] op,
                                         input int unsigned mul_len,
                                         input int unsigned act_len);
    int unsigned len;
    case (op)
      OP_LOADL, OP_LOADR, OP_STORE: len = 32'd1;
      OP_MUL, OP_MULADD:            len = mul_len;
      OP_MULACT, OP_MULADDACT:      len = act_len;
      default:                      len = 32'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/lvg_instr_fifo.sv
// Instruction queue for lvg_sched: DEPTH-entry FIFO with registered ready and
// no write-to-read bypass, so a pushed entry is visible only from the next cycle.
module lvg_instr_fifo
  import lvg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_instr,
  output logic       in_ready,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nx_s;
  logic          in_ready_r;
  logic          push_s;
  logic          pop_s;

  assign push_s   = in_valid && in_ready_r;
  assign pop_s    = pop && (count_r != {CW{1'b0}});
  assign in_ready = in_ready_r;
  assign head     = mem_r[rd_ptr_r];
  assign empty    = (count_r == {CW{1'b0}});

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nx_s = count_r;
    if (push_s && !pop_s) begin
      count_nx_s = count_r + CW'(1);
    end else if (!push_s && pop_s) begin
      count_nx_s = count_r - CW'(1);
    end else begin
      count_nx_s = count_r;
    end
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      in_ready_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r    <= count_nx_s;
      in_ready_r <= (count_nx_s != CW'(DEPTH));
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_instr;
    end
  end

endmodule

// File: rtl/lvg_sched.sv
// Matrix-engine instruction scheduler: queues opcodes, holds each on instr for
// its length, then inserts one idle cycle. Optional perf counters: LVG_SCHED_PERF_EN.
module lvg_sched
  import lvg_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MUL_CYCLES = 14,
  parameter int unsigned ACT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_instr,
  output logic        in_ready,
  output logic [7:0]  instr,
  output logic        busy,
  output logic        done,
  output logic        bad_op,
  output logic [31:0] perf_busy,
  output logic [31:0] perf_ops
);

  localparam int unsigned MAX_LEN = (MUL_CYCLES > ACT_CYCLES) ? MUL_CYCLES : ACT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1;

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [7:0]       cur_r;
  logic [7:0]       cur_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic [7:0]       instr_r;
  logic             busy_r;
  logic             done_r;
  logic             bad_r;
  logic             pop_s;
  logic [7:0]       head_s;
  logic             empty_s;

  lvg_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .pop      (pop_s),
    .head     (head_s),
    .empty    (empty_s)
  );

  // Next-state, pop and hold-counter logic.
  always_comb begin
    state_nx_s = state_r;
    cur_nx_s   = cur_r;
    cnt_nx_s   = cnt_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (!empty_s) begin
          pop_s      = 1'b1;
          state_nx_s = ST_RUN;
          cur_nx_s   = head_s;
          cnt_nx_s   = CNT_W'(op_len(head_s, MUL_CYCLES, ACT_CYCLES) - 32'd1);
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nx_s = ST_GAP;
        end else begin
          cnt_nx_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cur_r   <= OP_NOP;
      cnt_r   <= {CNT_W{1'b0}};
      instr_r <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bad_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cur_r   <= cur_nx_s;
      cnt_r   <= cnt_nx_s;
      instr_r <= ((state_nx_s == ST_RUN) && op_legal(cur_nx_s)) ? cur_nx_s : 8'd0;
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= (state_nx_s == ST_GAP);
      bad_r   <= (state_nx_s == ST_GAP) && !op_legal(cur_nx_s);
    end
  end

  assign instr  = instr_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign bad_op = bad_r;

`ifdef LVG_SCHED_PERF_EN
  logic [31:0] perf_busy_r;
  logic [31:0] perf_ops_r;

  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_r <= 32'd0;
      perf_ops_r  <= 32'd0;
    end else begin
      if (busy_r && (perf_busy_r != 32'hFFFF_FFFF)) perf_busy_r <= perf_busy_r + 32'd1;
      if (done_r && (perf_ops_r != 32'hFFFF_FFFF))  perf_ops_r  <= perf_ops_r + 32'd1;
    end
  end

  assign perf_busy = perf_busy_r;
  assign perf_ops  = perf_ops_r;
`else
  assign perf_busy = 32'd0;
  assign perf_ops  = 32'd0;
`endif

endmodule
